// File: rtl/etapa_id_ex.sv
// ID/EX pipeline register: decodes Opcode/Funct into AluOp, extends the immediate,
// bypasses operands from MEM/WB. Define FORWARDING_EN to compile in the bypass network.

module etapa_id_ex_fwd #(
  parameter int ANCHO = 32,
  parameter int NREG  = 5
) (
  input  logic             esc_mem,
  input  logic [NREG-1:0]  rd_mem,
  input  logic [ANCHO-1:0] dato_mem,
  input  logic             esc_wb,
  input  logic [NREG-1:0]  rd_wb,
  input  logic [ANCHO-1:0] dato_wb,
  input  logic [NREG-1:0]  rsel,
  input  logic [ANCHO-1:0] dato,
  output logic [ANCHO-1:0] res
);
`ifdef FORWARDING_EN
  // MEM is younger than WB, so its result wins; R0 is never forwarded
  always_comb begin
    res = dato;
    if (esc_mem && rd_mem != '0 && rd_mem == rsel)   res = dato_mem;
    else if (esc_wb && rd_wb != '0 && rd_wb == rsel) res = dato_wb;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{esc_mem, rd_mem, dato_mem, esc_wb, rd_wb, dato_wb, rsel};
  assign res = dato;
`endif
endmodule

module etapa_id_ex #(
  parameter int ANCHO = 32,
  parameter int NREG  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valido_in,
  output logic             Listo_in,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic [ANCHO-1:0] Dato1,
  input  logic [ANCHO-1:0] Dato2,
  input  logic [15:0]      Inmediato,
  input  logic [NREG-1:0]  Rs,
  input  logic [NREG-1:0]  Rt,
  input  logic [NREG-1:0]  Rd,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             EscReg_mem,
  input  logic             EscReg_wb,
  input  logic [NREG-1:0]  Rd_mem,
  input  logic [NREG-1:0]  Rd_wb,
  input  logic [ANCHO-1:0] Dato_mem,
  input  logic [ANCHO-1:0] Dato_wb,
  output logic             Valido_out,
  output logic [ANCHO-1:0] Ope1,
  output logic [ANCHO-1:0] Ope2,
  output logic [2:0]       AluOp,
  output logic [NREG-1:0]  RegDest,
  output logic             EscReg_out,
  output logic             Ilegal
);
  typedef struct packed {
    logic             vld;
    logic [ANCHO-1:0] ope1;
    logic [ANCHO-1:0] ope2;
    logic [2:0]       aluop;
    logic [NREG-1:0]  rd;
    logic             esc;
    logic             ilegal;
  } bundle_t;

  bundle_t nxt, q;
  logic             es_r, recon, sext;
  logic [2:0]       op;
  logic [ANCHO-1:0] imm_ext;

  logic [1:0][NREG-1:0]  rsel;
  logic [1:0][ANCHO-1:0] drf, fwd;
  assign rsel = {Rt, Rs};
  assign drf  = {Dato2, Dato1};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    etapa_id_ex_fwd #(.ANCHO(ANCHO), .NREG(NREG)) u_fwd (
      .esc_mem(EscReg_mem), .rd_mem(Rd_mem), .dato_mem(Dato_mem),
      .esc_wb(EscReg_wb),   .rd_wb(Rd_wb),   .dato_wb(Dato_wb),
      .rsel(rsel[i]), .dato(drf[i]), .res(fwd[i])
    );
  end

  always_comb begin
    es_r  = (Opcode == 6'b000000);
    recon = 1'b1;
    sext  = 1'b0;
    op    = 3'b000;
    if (es_r) begin
      case (Funct)
        6'b100100: op = 3'b000;
        6'b100101: op = 3'b001;
        6'b100000: op = 3'b010;
        6'b100010: op = 3'b110;
        6'b101010: op = 3'b111;
        6'b100111: op = 3'b100;
        6'b100110: op = 3'b101;
        default:   recon = 1'b0;
      endcase
    end else begin
      case (Opcode)
        6'b001000: begin op = 3'b010; sext = 1'b1; end
        6'b001010: begin op = 3'b111; sext = 1'b1; end
        6'b001100: op = 3'b000;
        6'b001101: op = 3'b001;
        6'b001110: op = 3'b101;
        default:   recon = 1'b0;
      endcase
    end
  end

  assign imm_ext = sext ? {{(ANCHO-16){Inmediato[15]}}, Inmediato}
                        : {{(ANCHO-16){1'b0}}, Inmediato};

  always_comb begin
    nxt = '0;
    if (Valido_in) begin
      nxt.vld    = 1'b1;
      nxt.ope1   = fwd[0];
      nxt.ope2   = es_r ? fwd[1] : imm_ext;
      nxt.aluop  = recon ? op : 3'b000;
      nxt.rd     = es_r ? Rd : Rt;
      nxt.esc    = recon && (nxt.rd != '0);
      nxt.ilegal = ~recon;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (Flush)  q <= '0;
    else if (!Stall) q <= nxt;
  end

  assign Listo_in   = ~Stall;
  assign Valido_out = q.vld;
  assign Ope1       = q.ope1;
  assign Ope2       = q.ope2;
  assign AluOp      = q.aluop;
  assign RegDest    = q.rd;
  assign EscReg_out = q.esc;
  assign Ilegal     = q.ilegal;
endmodule
